// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared MIPS decode constants and multiplier timer state encoding.
package cpu_defs;

  localparam int unsigned OP_W    = 6;
  localparam int unsigned FUNCT_W = 6;
  localparam int unsigned REG_W   = 5;

  // Opcodes
  localparam logic [OP_W-1:0] R_FORMAT = 6'd0;
  localparam logic [OP_W-1:0] J        = 6'd2;
  localparam logic [OP_W-1:0] BEQ      = 6'd4;
  localparam logic [OP_W-1:0] ADDIU    = 6'd9;
  localparam logic [OP_W-1:0] MADDU    = 6'd28;
  localparam logic [OP_W-1:0] LW       = 6'd35;
  localparam logic [OP_W-1:0] SW       = 6'd43;

  // R-format funct codes touching HI/LO
  localparam logic [FUNCT_W-1:0] MFHI  = 6'h10;
  localparam logic [FUNCT_W-1:0] MFLO  = 6'h12;
  localparam logic [FUNCT_W-1:0] MULTU = 6'h19;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mul_state_e;

endpackage

// File: rtl/mul_latency_timer.sv
// Tracks the HI/LO multiplier occupancy window and issues the writeback strobe.
module mul_latency_timer
  import cpu_defs::*;
#(
  parameter int unsigned MUL_LAT = 4,
  parameter int unsigned CNT_W   = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic mul_start_i,
  output logic mul_busy_o,
  output logic hilo_we_o,
  output logic mul_err_o
);

  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

  mul_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             hilo_we_q;
  logic             mul_err_q;

  // BUSY counts RELOAD..1, then spends one cycle at cnt==0 with the strobe high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      hilo_we_q <= 1'b0;
      mul_err_q <= 1'b0;
    end else begin
      hilo_we_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (mul_start_i) begin
            state_q <= BUSY;
            cnt_q   <= RELOAD;
          end
        end
        BUSY: begin
          if (cnt_q > ONE) begin
            cnt_q <= cnt_q - ONE;
            if (mul_start_i) mul_err_q <= 1'b1;
          end else if (cnt_q == ONE) begin
            cnt_q     <= '0;
            hilo_we_q <= 1'b1;
            if (mul_start_i) mul_err_q <= 1'b1;
          end else if (mul_start_i) begin
            // Start coinciding with the strobe chains straight into a new window.
            cnt_q <= RELOAD;
          end else begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign mul_busy_o = (state_q == BUSY);
  assign hilo_we_o  = hilo_we_q;
  assign mul_err_o  = mul_err_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush scheduler for the 5-stage pipeline: load-use, control and HI/LO hazards.
module pipeline_hazard_ctrl
  import cpu_defs::*;
#(
  parameter int unsigned MUL_LAT = 4,
  parameter int unsigned CNT_W   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [OP_W-1:0]    id_opcode,
  input  logic [FUNCT_W-1:0] id_funct,
  input  logic [REG_W-1:0]   id_rs,
  input  logic [REG_W-1:0]   id_rt,
  input  logic               idex_mem_read,
  input  logic [REG_W-1:0]   idex_rt,
  input  logic               ex_mul_start,
  input  logic               ex_branch_taken,
  input  logic               ex_jump,
  output logic               pc_write,
  output logic               ifid_write,
  output logic               ifid_flush,
  output logic               idex_bubble,
  output logic               mul_busy,
  output logic               hilo_we,
  output logic               mul_err
);

  logic uses_rt;
  logic hilo_use;
  logic load_use;
  logic mul_stall;
  logic flush;
  logic stall;

  mul_latency_timer #(
    .MUL_LAT (MUL_LAT),
    .CNT_W   (CNT_W)
  ) u_mul_timer (
    .clk         (clk),
    .rst         (rst),
    .mul_start_i (ex_mul_start),
    .mul_busy_o  (mul_busy),
    .hilo_we_o   (hilo_we),
    .mul_err_o   (mul_err)
  );

  // ID decode and hazard detection.
  always_comb begin
    uses_rt  = (id_opcode == R_FORMAT) || (id_opcode == MADDU) ||
               (id_opcode == SW)       || (id_opcode == BEQ);
    hilo_use = ((id_opcode == R_FORMAT) &&
                ((id_funct == MFHI) || (id_funct == MFLO) || (id_funct == MULTU))) ||
               (id_opcode == MADDU);
    load_use = idex_mem_read && (idex_rt != '0) &&
               ((idex_rt == id_rs) || (uses_rt && (idex_rt == id_rt)));
    // The reader may proceed on the strobe cycle: HI/LO write-before-read is guaranteed.
    mul_stall = mul_busy && hilo_use && !hilo_we;
    flush     = ex_branch_taken || ex_jump;
    stall     = load_use || mul_stall;
  end

  // Priority mux: a squash beats any stall on the squashed instruction.
  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    if (flush) begin
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else if (stall) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
    end
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central stall/flush scheduler for the 5-stage MIPS pipeline (IF/ID/EX/MEM/WB).
- Resolves three hazard classes:
  - load-use data hazards, detected against the ID/EX stage;
  - control hazards from taken branches and jumps resolved in EX;
  - structural/data hazards on the shared multi-cycle HI/LO multiplier used by MULTU and MADDU.
- Drives the PC write enable, the IF/ID register write enable and flush, and the ID/EX bubble insertion.
- Sequences the multiplier busy window and the HI/LO writeback pulse.

Parameters:
- MUL_LAT, 4, multiplier latency in cycles from EX issue to HI/LO write. Legal range 2..15.
- CNT_W, 4, width of the latency counter. Must satisfy 2^CNT_W > MUL_LAT.

Ports:
- clk  in  1  pipeline clock, rising-edge.
- rst  in  1  asynchronous, active-high reset.
- id_opcode  in  6  opcode of the instruction in ID.
- id_funct  in  6  funct field of the instruction in ID.
- id_rs  in  5  rs of the instruction in ID.
- id_rt  in  5  rt of the instruction in ID.
- idex_mem_read  in  1  MemRead of the instruction in ID/EX.
- idex_rt  in  5  destination rt of the instruction in ID/EX.
- ex_mul_start  in  1  one-cycle pulse: MULTU/MADDU is in EX this cycle.
- ex_branch_taken  in  1  BEQ resolved taken in EX.
- ex_jump  in  1  J in EX.
- pc_write  out  1  PC update enable.
- ifid_write  out  1  IF/ID register load enable.
- ifid_flush  out  1  clears IF/ID to NOP.
- idex_bubble  out  1  zeroes the ID/EX control fields.
- mul_busy  out  1  multiplier is occupied.
- hilo_we  out  1  one-cycle HI/LO write strobe.
- mul_err  out  1  sticky flag: mul_start was seen while busy.

Behaviour:
- Reset: rst is asynchronous and active-high. It forces state=IDLE, cnt=0 and mul_err=0.
- Outputs in reset, or in IDLE with all requests low: pc_write=1, ifid_write=1, ifid_flush=0, idex_bubble=0, mul_busy=0, hilo_we=0, mul_err=0.
- ID decode (combinational):
  - uses_rt = opcode in {0 (R), 28 (MADDU), 43 (SW), 4 (BEQ)}.
  - hilo_use = (opcode==0 and funct in {0x10 MFHI, 0x12 MFLO, 0x19 MULTU}) or opcode==28.
- load_use = idex_mem_read and idex_rt!=0 and (idex_rt==id_rs or (uses_rt and idex_rt==id_rt)).
- State machine: IDLE and BUSY, with counter cnt.
  - IDLE, on ex_mul_start: go to BUSY, cnt=MUL_LAT-1.
  - BUSY with cnt>1: decrement cnt.
  - BUSY with cnt==1: hilo_we=1 on the next cycle, then IDLE. The HI/LO write lands exactly MUL_LAT cycles after the start pulse.
  - Back-to-back: ex_mul_start in the same cycle hilo_we is high is accepted. The block reloads BUSY with cnt=MUL_LAT-1 and suffers no gap.
  - ex_mul_start in BUSY at any other time sets mul_err (sticky until rst) and is otherwise ignored.
- mul_busy = (state==BUSY), registered.
- mul_stall = mul_busy and hilo_use and not (hilo_we on this cycle).
- Outputs are combinational from registered state and the current inputs, evaluated in this priority:
  1. flush = ex_branch_taken or ex_jump: pc_write=1, ifid_flush=1, idex_bubble=1, ifid_write=1. Any stall is dropped because the ID instruction is squashed.
  2. stall = load_use or mul_stall: pc_write=0, ifid_write=0, idex_bubble=1, ifid_flush=0.
  3. Otherwise: the default outputs listed under Reset.
- Load-use stall lasts exactly one cycle, because the bubble clears idex_mem_read.
- Mul stall lasts until the cycle hilo_we=1. The dependent instruction proceeds in that same cycle, since HI/LO write-before-read is guaranteed in the register file.
- Register $0 never causes a stall.
- Reset mid-BUSY: the in-flight multiply is abandoned, hilo_we is not pulsed, and the block returns to IDLE immediately.

Decomposition:
- Shared package (cpu_defs):
  - opcode constants R_FORMAT, ADDIU, LW, SW, BEQ, J, MADDU;
  - funct constants MFHI, MFLO, MULTU;
  - 1-bit state encoding IDLE/BUSY.
- One sub-module, mul_latency_timer: holds the state register and cnt, and produces mul_busy, hilo_we and mul_err from ex_mul_start.
- The top level holds the decode, hazard comparators and the priority mux.

Test Plan:
- LW $5 in ID/EX (idex_mem_read=1, idex_rt=5), ADD with rs=5 in ID -> one cycle of pc_write=0, ifid_write=0, idex_bubble=1, then defaults resume. Repeat with idex_rt=0 -> no stall.
- LW rt=7 followed by ADDIU rs=3, rt=7 (uses_rt=0) -> no stall. SW with rt=7 -> one-cycle stall.
- MUL_LAT=4: ex_mul_start at cycle 0, MFLO in ID from cycle 1 -> mul_busy=1 and stall in cycles 1–3, hilo_we=1 at cycle 4, MFLO advances at cycle 4, mul_busy=0 at cycle 5.
- MADDU start, and a second start pulse coinciding with hilo_we -> no idle gap, second hilo_we 4 cycles later, mul_err=0. A start pulse at cycle 2 of BUSY -> mul_err=1 and it stays 1.
- ex_branch_taken=1 in the same cycle as load_use=1 -> ifid_flush=1, idex_bubble=1, pc_write=1, ifid_write=1 (flush wins).
- rst asserted asynchronously mid-BUSY at cnt=2 -> all outputs at reset values immediately, and no hilo_we afterwards.
